// File: rtl/data_stack.sv
// Data-stack storage stage: top two entries in dedicated registers, deeper
// entries in a pointer-addressed register array, with sticky misuse flags.
module data_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [2:0]                 stackOP,
  input  logic [WIDTH-1:0]           writeData,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AD = DEPTH - 2;
  localparam int AW = (AD > 1) ? $clog2(AD) : 1;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_PAR  = 3'd2;
  localparam logic [2:0] OP_POP  = 3'd3;
  localparam logic [2:0] OP_POP2 = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;

  // No handshake: one command is consumed at every rising edge of CLK.
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] second_q, second_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [AD];

  logic [CW-1:0]    idx2_full, idx3_full, widx_full;
  logic [AW-1:0]    idx2, idx3, widx;
  logic [WIDTH-1:0] entry2, entry3;
  logic             mem_we;

  // The array is filled bottom-up: the entry just below `second` sits at count-3.
  assign idx2_full = count_q - CW'(3);
  assign idx3_full = count_q - CW'(4);
  assign widx_full = count_q - CW'(2);
  assign idx2      = idx2_full[AW-1:0];
  assign idx3      = idx3_full[AW-1:0];
  assign widx      = widx_full[AW-1:0];
  assign entry2    = (count_q >= CW'(3)) ? mem_q[idx2] : '0;
  assign entry3    = (count_q >= CW'(4)) ? mem_q[idx3] : '0;

  always_comb begin
    top_d    = top_q;
    second_d = second_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mem_we   = 1'b0;
    case (stackOP)
      OP_PUSH: begin
        if (count_q < CW'(DEPTH)) begin
          top_d    = writeData;
          second_d = top_q;
          count_d  = count_q + CW'(1);
          mem_we   = (count_q >= CW'(2));
        end else begin
          ovf_d = 1'b1;
        end
      end
      OP_PAR: begin
        if (count_q >= CW'(2)) begin
          top_d    = writeData;
          second_d = entry2;
          count_d  = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_POP: begin
        if (count_q >= CW'(1)) begin
          top_d    = second_q;
          second_d = entry2;
          count_d  = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_POP2: begin
        if (count_q >= CW'(2)) begin
          top_d    = entry2;
          second_d = entry3;
          count_d  = count_q - CW'(2);
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_SWAP: begin
        if (count_q >= CW'(2)) begin
          top_d    = second_q;
          second_d = top_q;
        end else begin
          unf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      top_q    <= '0;
      second_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      top_q    <= top_d;
      second_q <= second_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Array contents are never visible past the count, so they need no reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[widx] <= second_q;
  end

  assign top       = top_q;
  assign second    = second_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack: directed scenarios plus random ops against a queue model.
module tb_data_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic             CLK;
  logic             reset;
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] writeData;
  logic [WIDTH-1:0] top, second;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf, m_unf;

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset(reset), .stackOP(stackOP), .writeData(writeData),
    .top(top), .second(second), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".top"},    32'(top),    (n > 0) ? 32'(exp_q[0]) : 32'd0);
    check({tag, ".second"}, 32'(second), (n > 1) ? 32'(exp_q[1]) : 32'd0);
    check({tag, ".count"},  32'(count),  32'(n));
    check({tag, ".empty"},  32'(empty),  32'(n == 0));
    check({tag, ".full"},   32'(full),   32'(n == DEPTH));
    check({tag, ".ovf"},    32'(overflow),  32'(m_ovf));
    check({tag, ".unf"},    32'(underflow), 32'(m_unf));
  endtask

  // Reference model: exp_q[0] is the top of stack.
  task automatic model_op(input logic [2:0] op, input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] t;
    int n;
    n = exp_q.size();
    case (op)
      3'd1: if (n < DEPTH) exp_q.push_front(wd); else m_ovf = 1'b1;
      3'd2: if (n >= 2) begin
              t = exp_q.pop_front(); t = exp_q.pop_front(); exp_q.push_front(wd);
            end else m_unf = 1'b1;
      3'd3: if (n >= 1) t = exp_q.pop_front(); else m_unf = 1'b1;
      3'd4: if (n >= 2) begin
              t = exp_q.pop_front(); t = exp_q.pop_front();
            end else m_unf = 1'b1;
      3'd5: if (n >= 2) begin
              t = exp_q[0]; exp_q[0] = exp_q[1]; exp_q[1] = t;
            end else m_unf = 1'b1;
      default: ;
    endcase
  endtask

  // driver
  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] wd, input string tag);
    @(negedge CLK);
    stackOP   = op;
    writeData = wd;
    @(posedge CLK);
    model_op(op, wd);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    stackOP = 3'd0;
    #2 reset = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1 check_all(tag);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0]       op;
    logic [WIDTH-1:0] wd;
    reset     = 1'b0;
    stackOP   = 3'd0;
    writeData = '0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    #1 check_all("rst_init");
    repeat (2) @(negedge CLK);
    reset = 1'b1;

    // reset mid-stream
    for (int i = 0; i < 5; i++) do_op(3'd1, WIDTH'(100 + i), "push5");
    do_reset("rst_mid");
    do_op(3'd1, 16'h1234, "push1234");
    check("tp_1234", 32'(top), 32'h1234);

    // POPANDREPLACE down to one entry, then illegal SWAP
    do_reset("rst_b");
    do_op(3'd1, 16'd3, "p3");
    do_op(3'd1, 16'd5, "p5");
    do_op(3'd2, 16'd8, "par8");
    check("par_second0", 32'(second), 32'd0);
    do_op(3'd5, 16'd0, "swap_unf");
    check("swap_unf_top", 32'(top), 32'd8);

    // fill, overflow, drain
    do_reset("rst_c");
    for (int i = 1; i <= DEPTH; i++) do_op(3'd1, WIDTH'(i), "fill");
    check("full_flag", 32'(full), 32'd1);
    do_op(3'd1, 16'd99, "push_ovf");
    check("ovf_top", 32'(top), 32'd16);
    for (int i = 0; i < DEPTH; i++) do_op(3'd3, 16'd0, "drain");
    check("drain_empty", 32'(empty), 32'd1);

    // SWAP then POP2
    do_reset("rst_d");
    for (int i = 1; i <= 4; i++) do_op(3'd1, WIDTH'(10 * i), "p10x");
    do_op(3'd5, 16'd0, "swap");
    check("swap_top", 32'(top), 32'd30);
    do_op(3'd4, 16'd0, "pop2");
    check("pop2_top", 32'(top), 32'd20);

    // sticky underflow
    do_reset("rst_e");
    do_op(3'd3, 16'd0, "pop_empty");
    for (int i = 0; i < 10; i++) do_op(3'd0, 16'd0, "idle");
    do_op(3'd1, 16'd7, "p7");
    check("unf_sticky", 32'(underflow), 32'd1);

    // reserved codes
    do_reset("rst_f");
    do_op(3'd1, 16'd1, "p1");
    do_op(3'd1, 16'd2, "p2");
    do_op(3'd6, 16'hFFFF, "op6");
    do_op(3'd7, 16'hFFFF, "op7");
    check("op67_top", 32'(top), 32'd2);

    // random: alternate push-heavy and pop-heavy phases
    do_reset("rst_r");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
      else if (((i / 40) % 2) == 0) op = 3'd1;
      else op = 3'($urandom_range(2, 5));
      wd = WIDTH'($urandom);
      do_op(op, wd, "rand");
      if ($urandom_range(0, 149) == 0) do_reset("rst_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
